fig4_12_checker: RTL

- Clocked exhaustive stimulus/response checker for the fig4_12 gate-level circuit (F = X·Z + Y'·Z + X'·Y·Z').
- Acts as the opposite end of the fig4_12 interface: it drives X, Y, Z and consumes F.
- Walks all 8 input vectors and waits a programmable settle time so gate delays can resolve.
- Samples F, compares it against a truth-table constant, and reports pass/fail, mismatch count and a per-vector fail map.

---
 rtl/fig4_12_pkg.sv | 21 ++
 rtl/fig4_12_settle_timer.sv | 29 ++
 rtl/fig4_12_checker.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fig4_12_pkg.sv
// Shared types and constants for the fig4_12 stimulus/response checker.
package fig4_12_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth table of F = X&Z | ~Y&Z | ~X&Y&~Z, bit i is F for {X,Y,Z} = i.
  localparam logic [7:0] FIG4_12_EXPECT = 8'hA6;

  // Index of the input vector currently applied, equal to {X,Y,Z}.
  typedef logic [2:0] vec_t;

  // Last vector of a sweep.
  localparam vec_t LAST_VEC = 3'd7;

endpackage

// File: rtl/fig4_12_settle_timer.sv
// Load/decrement settle counter; expire is high while the count equals one,
// marking the final settle cycle before F is sampled.
module fig4_12_settle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down while running, stopping at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/fig4_12_checker.sv
// Exhaustive checker for the fig4_12 circuit: drives all eight {X,Y,Z}
// vectors, waits SETTLE_CYCLES per vector, samples F and records mismatches.
// Optional macro FIG4_12_CHECKER_FIRST_FAIL_EN adds first_fail/first_valid,
// reporting the index of the first mismatching vector of a sweep.
module fig4_12_checker
  import fig4_12_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECT        = FIG4_12_EXPECT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       F,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
`ifdef FIG4_12_CHECKER_FIRST_FAIL_EN
  ,
  output logic [2:0] first_fail,
  output logic       first_valid
`endif
);

  generate
    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
      $error("fig4_12_checker: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t state;
  vec_t   vec;
  logic   mismatch;
  logic   accept;
  logic   timer_load;
  logic   expire;

  // The applied vector is the registered index itself.
  assign {X, Y, Z} = vec;

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign timer_load = accept || ((state == SAMPLE) && (vec != LAST_VEC));

  // An unknown F fails the equality test and therefore counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (F == EXPECT[vec]) mismatch = 1'b0;
  end

  fig4_12_settle_timer #(.WIDTH(4)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .run        (state == SETTLE),
    .expire     (expire)
  );

  // Sweep controller: start, settle, sample, advance, and hold results in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vec         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_vec    <= '0;
`ifdef FIG4_12_CHECKER_FIRST_FAIL_EN
      first_fail  <= '0;
      first_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= SETTLE;
            vec         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_vec    <= '0;
`ifdef FIG4_12_CHECKER_FIRST_FAIL_EN
            first_fail  <= '0;
            first_valid <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (expire) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count     <= err_count + 4'd1;
            fail_vec[vec] <= 1'b1;
`ifdef FIG4_12_CHECKER_FIRST_FAIL_EN
            if (!first_valid) begin
              first_fail  <= vec;
              first_valid <= 1'b1;
            end
`endif
          end
          if (vec == LAST_VEC) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 4'd0) && !mismatch;
          end else begin
            state <= SETTLE;
            vec   <= vec + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
